// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
// The legality helper is the single definition of a fetchable word address.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // The 65-bit sum makes addresses that wrap past 2^64 count as out of range.
    function automatic logic fetch_legal(input logic [PC_WIDTH-1:0] addr,
                                         input int unsigned mem_bytes);
        return (addr[1:0] == 2'b00) &&
               (({1'b0, addr} + 65'd3) < 65'(mem_bytes));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and
// simultaneous enqueue/dequeue; the head entry is always visible on rd_data.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          enq,
    input  logic          deq,
    input  fetch_entry_t  wr_data,
    output fetch_entry_t  rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    fetch_entry_t  entries [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rd_data = entries[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    // Pointers are PW bits wide, so a power-of-two DEPTH wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                entries[wr_ptr] <= wr_data;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: owns the fetch PC and RUN/FAULT state, reads the
// combinational instruction memory and feeds decode through fetch_queue.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] PC_RESET    = 64'h0,
    parameter int unsigned         MEM_BYTES   = 128,
    parameter int unsigned         QUEUE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    read_address,
    input  logic [INSTR_WIDTH-1:0] instruction,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [PC_WIDTH-1:0]    if_pc,
    input  logic                   if_ready,
    output logic                   fault
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic                pc_legal;
    logic                target_legal;
    logic                enq;
    logic                deq;
    logic                q_full;
    logic                q_empty;
    logic [CW-1:0]       count_unused;
    fetch_entry_t        wr_entry;
    fetch_entry_t        head;

    assign read_address = fetch_pc;
    assign pc_legal     = fetch_legal(fetch_pc, MEM_BYTES);
    assign target_legal = fetch_legal(branch_target, MEM_BYTES);

    // Valid/ready: the head transfers on a cycle with if_valid && if_ready;
    // a redirect overrides both sides, discarding the head and the fetch.
    assign deq = !q_empty && if_ready && !branch_taken;
    assign enq = (state == RUN) && pc_legal && !branch_taken && (!q_full || deq);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = instruction;

    assign if_valid = !q_empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .flush   (branch_taken),
        .enq     (enq),
        .deq     (deq),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count_unused),
        .full    (q_full),
        .empty   (q_empty)
    );

    // A redirect in RUN never traps directly; an illegal target is caught
    // on the following cycle when it becomes fetch_pc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            fetch_pc <= PC_RESET;
            fault    <= 1'b0;
        end else if (branch_taken) begin
            fetch_pc <= branch_target;
            if (state == FAULT && target_legal) begin
                state <= RUN;
                fault <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!pc_legal) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (enq) begin
                        fetch_pc <= fetch_pc + PC_WIDTH'(INSTR_BYTES);
                    end
                end
                FAULT: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural queue model checked every
// cycle plus directed literal checks, including a run-off instance at PC 120.
module tb_instruction_fetch_unit;

    localparam int MEMB = 128;
    localparam int QD   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] read_address;
    logic [31:0] instruction;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_ready;
    logic        fault;

    logic [63:0] ra2;
    logic [31:0] instr2;
    logic        iv2;
    logic [31:0] ii2;
    logic [63:0] ip2;
    logic        f2;

    logic [7:0]  mem [MEMB];
    int          mem_ver = 0;

    int          vectors = 0;
    int          errors  = 0;
    bit          chk_en  = 0;

    logic [63:0] m_pc;
    bit          m_fault;
    logic [95:0] exp_q [$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .read_address  (read_address),
        .instruction   (instruction),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_ready      (if_ready),
        .fault         (fault)
    );

    instruction_fetch_unit #(
        .PC_RESET    (64'd120),
        .MEM_BYTES   (128),
        .QUEUE_DEPTH (2)
    ) dut2 (
        .clk           (clk),
        .reset         (reset),
        .read_address  (ra2),
        .instruction   (instr2),
        .branch_taken  (1'b0),
        .branch_target (64'h0),
        .if_valid      (iv2),
        .if_instr      (ii2),
        .if_pc         (ip2),
        .if_ready      (1'b1),
        .fault         (f2)
    );

    function automatic logic in_range(input logic [63:0] a);
        return ({1'b0, a} + 65'd3) < 65'(MEMB);
    endfunction

    function automatic logic m_legal(input logic [63:0] a);
        return (a[1:0] == 2'b00) && in_range(a);
    endfunction

    function automatic logic [31:0] rd_word(input logic [63:0] a);
        int i;
        if (!in_range(a)) return 32'h0;
        i = int'(a[6:0]);
        return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
    endfunction

    always @(read_address, mem_ver) instruction = rd_word(read_address);
    always @(ra2, mem_ver) instr2 = rd_word(ra2);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one step per clock edge, straight from the fetch rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc    = 64'h0;
            m_fault = 0;
            exp_q.delete();
        end else if (branch_taken) begin
            exp_q.delete();
            if (m_fault && m_legal(branch_target)) m_fault = 0;
            m_pc = branch_target;
        end else begin
            bit had_room;
            bit took;
            had_room = exp_q.size() < QD;
            took     = (exp_q.size() > 0) && if_ready;
            if (took) void'(exp_q.pop_front());
            if (!m_fault) begin
                if (!m_legal(m_pc)) begin
                    m_fault = 1;
                end else if (had_room || took) begin
                    exp_q.push_back({m_pc, rd_word(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("read_address", read_address, m_pc);
            check("fault", 64'(fault), 64'(m_fault));
            check("if_valid", 64'(if_valid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("if_pc", if_pc, exp_q[0][95:32]);
                check("if_instr", 64'(if_instr), 64'(exp_q[0][31:0]));
            end
        end
    end

    task automatic reset_pulse();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int sel;
        logic [63:0] tgt;
        reset         = 1'b1;
        if_ready      = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom_range(0, 255));
        {mem[3], mem[2], mem[1], mem[0]} = 32'hAABBCCDD;
        {mem[7], mem[6], mem[5], mem[4]} = 32'h11223344;
        mem_ver++;
        #12;
        check("rst read_address", read_address, 64'h0);
        check("rst read_address2", ra2, 64'd120);
        check("rst if_valid", 64'(if_valid), 64'h0);
        check("rst if_instr", 64'(if_instr), 64'h0);
        check("rst if_pc", if_pc, 64'h0);
        check("rst fault", 64'(fault), 64'h0);
        chk_en = 1;
        cyc();
        reset    = 1'b0;
        if_ready = 1'b1;

        // First two words back to back; run-off instance in parallel.
        cyc();
        check("first pc", if_pc, 64'h0);
        check("first instr", 64'(if_instr), 64'hAABBCCDD);
        check("runoff pc120", ip2, 64'd120);
        check("runoff instr120", 64'(ii2), 64'(rd_word(64'd120)));
        cyc();
        check("second pc", if_pc, 64'h4);
        check("second instr", 64'(if_instr), 64'h11223344);
        check("runoff pc124", ip2, 64'd124);
        check("runoff valid124", 64'(iv2), 64'h1);
        check("runoff fault_early", 64'(f2), 64'h0);
        cyc();
        check("runoff fault", 64'(f2), 64'h1);
        check("runoff valid_after", 64'(iv2), 64'h0);
        check("runoff addr_hold", ra2, 64'd128);

        // Backpressure.
        reset_pulse();
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp instr_hold", 64'(if_instr), 64'hAABBCCDD);
        end
        check("bp pc_stop", read_address, 64'h8);
        if_ready = 1'b1;
        cyc();
        check("bp release pc4", if_pc, 64'h4);
        cyc();
        check("bp release pc8", if_pc, 64'h8);
        check("bp release valid", 64'(if_valid), 64'h1);

        // Redirect while full.
        if_ready      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 64'h20;
        cyc();
        branch_taken = 1'b0;
        check("redir valid", 64'(if_valid), 64'h0);
        check("redir addr", read_address, 64'h20);
        cyc();
        check("redir head", if_pc, 64'h20);

        // Misaligned redirect, then recovery.
        branch_taken  = 1'b1;
        branch_target = 64'h22;
        cyc();
        branch_taken = 1'b0;
        check("mis fault_early", 64'(fault), 64'h0);
        cyc();
        check("mis fault", 64'(fault), 64'h1);
        check("mis addr", read_address, 64'h22);
        cyc();
        check("mis noenq", 64'(if_valid), 64'h0);
        check("mis addr_hold", read_address, 64'h22);
        branch_taken  = 1'b1;
        branch_target = 64'h10;
        cyc();
        branch_taken = 1'b0;
        if_ready     = 1'b1;
        check("recover fault", 64'(fault), 64'h0);
        check("recover addr", read_address, 64'h10);
        cyc();
        check("recover head", if_pc, 64'h10);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            if_ready     = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 7) == 0);
            sel          = int'($urandom_range(0, 7));
            if (sel == 0)      tgt = 64'($urandom_range(0, 127)) | 64'h1;
            else if (sel == 1) tgt = 64'd128 + 64'($urandom_range(0, 3)) * 64'd4;
            else if (sel == 2) tgt = 64'hFFFF_FFFF_FFFF_FFFC;
            else               tgt = 64'($urandom_range(0, 31)) * 64'd4;
            branch_target = tgt;
            cyc();
        end

        // Async reset between edges.
        if_ready      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 64'h40;
        cyc();
        branch_taken = 1'b0;
        cyc();
        cyc();
        #3;
        reset = 1'b1;
        #1;
        check("async read_address", read_address, 64'h0);
        check("async if_valid", 64'(if_valid), 64'h0);
        check("async if_pc", if_pc, 64'h0);
        check("async if_instr", 64'(if_instr), 64'h0);
        check("async fault", 64'(fault), 64'h0);
        cyc();
        reset    = 1'b0;
        if_ready = 1'b1;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
